// File: rtl/radiation_sensor_app_pkg.sv
// Shared command/reply codes, reply buffer type and FSM state encoding for the
// radiation sensor tag application layer.
package radiation_sensor_app_pkg;

  localparam logic [7:0] CMD_READ_COUNT   = 8'h01;
  localparam logic [7:0] CMD_CLEAR        = 8'h02;
  localparam logic [7:0] CMD_READ_VERSION = 8'h03;

  localparam logic [7:0] RSP_READ_COUNT   = 8'h81;
  localparam logic [7:0] RSP_CLEAR        = 8'h82;
  localparam logic [7:0] RSP_READ_VERSION = 8'h83;
  localparam logic [7:0] RSP_UNKNOWN      = 8'hFF;

  localparam int REPLY_DEPTH = 4;

  typedef logic [REPLY_DEPTH-1:0][7:0] reply_buf_t;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    DECODE,
    TX
  } AppState;

endpackage

// File: rtl/hit_edge_detector.sv
// Two-flop synchroniser for the asynchronous hit level plus a one-cycle
// rising-edge pulse; synchronous active-high reset.
module hit_edge_detector (
  input  logic clk,
  input  logic rst,
  input  logic hit_async,
  output logic hit_pulse
);

  // [0],[1] form the synchroniser, [2] is the previous synchronised level.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], hit_async};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign hit_pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/radiation_sensor_app.sv
// Radiation sensor tag application layer: hit counter, one-byte command decode
// and reply framing. RADIATION_SENSOR_APP_OVFL_STATUS_EN adds the ovf status byte.
module radiation_sensor_app #(
  parameter logic [7:0] VERSION = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hit_async,
  input  logic       rx_soc,
  input  logic       rx_eoc,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_error,
  input  logic       resend_last,
  input  logic       tx_req,
  output logic [7:0] tx_data,
  output logic       tx_data_valid
);

  import radiation_sensor_app_pkg::*;

  logic hit_pulse;

  AppState    state_q,     state_d;
  logic [15:0] count_q,    count_d;
  logic        ovf_q,      ovf_d;
  logic [1:0]  rx_cnt_q,   rx_cnt_d;
  logic [7:0]  rx_byte_q,  rx_byte_d;
  reply_buf_t  buf_q,      buf_d;
  logic [2:0]  reply_len_q, reply_len_d;
  logic [1:0]  idx_q,      idx_d;
  logic [7:0]  tx_data_q,  tx_data_d;
  logic        tx_valid_q, tx_valid_d;

  reply_buf_t  reply_w;
  logic [2:0]  reply_len_w;

  hit_edge_detector u_hit_edge_detector (
    .clk       (clk),
    .rst       (rst),
    .hit_async (hit_async),
    .hit_pulse (hit_pulse)
  );

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    reply_w     = '0;
    reply_len_w = 3'd1;
    case (rx_byte_q)
      CMD_READ_COUNT: begin
`ifdef RADIATION_SENSOR_APP_OVFL_STATUS_EN
        reply_w     = {count_q[7:0], count_q[15:8], {7'b0, ovf_q}, RSP_READ_COUNT};
        reply_len_w = 3'd4;
`else
        reply_w     = {8'h00, count_q[7:0], count_q[15:8], RSP_READ_COUNT};
        reply_len_w = 3'd3;
`endif
      end
      CMD_CLEAR: begin
        reply_w[0] = RSP_CLEAR;
      end
      CMD_READ_VERSION: begin
        reply_w[0]  = RSP_READ_VERSION;
        reply_w[1]  = VERSION;
        reply_len_w = 3'd2;
      end
      default: begin
        reply_w[0] = RSP_UNKNOWN;
      end
    endcase
  end

  // NOTE: blocking assignments here because later lines read earlier results in the same evaluation (e.g. rx_cnt_d, idx_d).
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    rx_cnt_d    = rx_cnt_q;
    rx_byte_d   = rx_byte_q;
    buf_d       = buf_q;
    reply_len_d = reply_len_q;
    idx_d       = idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;

    if (hit_pulse) begin
      if (count_q == 16'hFFFF) ovf_d = 1'b1;
      else                     count_d = count_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (rx_soc) begin
          state_d  = RX;
          rx_cnt_d = '0;
        end else if (resend_last && reply_len_q != 3'd0) begin
          state_d    = TX;
          idx_d      = '0;
          tx_data_d  = buf_q[0];
          tx_valid_d = 1'b1;
        end
      end
      RX: begin
        if (rx_soc) begin
          rx_cnt_d = '0;
        end else begin
          if (rx_data_valid) begin
            if (rx_cnt_q == 2'd0) rx_byte_d = rx_data;
            if (rx_cnt_q != 2'd2) rx_cnt_d = rx_cnt_q + 2'd1;
          end
          if (rx_eoc) state_d = (rx_cnt_d == 2'd1 && !rx_error) ? DECODE : IDLE;
        end
      end
      DECODE: begin
        buf_d       = reply_w;
        reply_len_d = reply_len_w;
        idx_d       = '0;
        tx_data_d   = reply_w[0];
        tx_valid_d  = 1'b1;
        state_d     = TX;
        // Overrides the hit increment above: a hit coinciding with CLEAR is dropped.
        if (rx_byte_q == CMD_CLEAR) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      TX: begin
        if (rx_soc) begin
          state_d    = RX;
          rx_cnt_d   = '0;
          tx_valid_d = 1'b0;
          tx_data_d  = '0;
        end else if (tx_req) begin
          if ({1'b0, idx_q} == reply_len_q - 3'd1) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_data_d  = '0;
          end else begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = buf_q[idx_d];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the reply buffer is reset too, so a resend after reset finds reply_len 0 and stale data never leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      rx_cnt_q    <= '0;
      rx_byte_q   <= '0;
      buf_q       <= '0;
      reply_len_q <= '0;
      idx_q       <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_byte_q   <= rx_byte_d;
      buf_q       <= buf_d;
      reply_len_q <= reply_len_d;
      idx_q       <= idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_data_valid = tx_valid_q;

endmodule

// File: tb/tb_radiation_sensor_app.sv
// Directed bench for radiation_sensor_app: expected reply bytes are queued when a
// command is sent and popped as the DUT presents them.
module tb_radiation_sensor_app;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit_async = 1'b0;
  logic       rx_soc = 1'b0;
  logic       rx_eoc = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       resend_last = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_q[$];
  logic [15:0] m_count = 16'h0000;
  logic        m_ovf = 1'b0;

  radiation_sensor_app #(.VERSION(8'h01)) dut (
    .clk           (clk),
    .rst           (rst),
    .hit_async     (hit_async),
    .rx_soc        (rx_soc),
    .rx_eoc        (rx_eoc),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_error      (rx_error),
    .resend_last   (resend_last),
    .tx_req        (tx_req),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hit();
    hit_async = 1'b1;
    repeat (2) tick();
    hit_async = 1'b0;
    repeat (2) tick();
    if (m_count == 16'hFFFF) m_ovf = 1'b1;
    else                     m_count = m_count + 16'd1;
  endtask

  // n bytes (0..2); optional hit timed so its edge pulse lands in the DECODE cycle.
  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input int n,
                            input logic err, input logic decode_hit);
    rx_soc = 1'b1;
    tick();
    rx_soc = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_data       = (i == 0) ? b0 : b1;
      rx_data_valid = 1'b1;
      if (decode_hit) hit_async = 1'b1;
      tick();
      rx_data_valid = 1'b0;
    end
    rx_eoc   = 1'b1;
    rx_error = err;
    tick();
    rx_eoc    = 1'b0;
    rx_error  = 1'b0;
    hit_async = 1'b0;
  endtask

  task automatic push_count();
    exp_q.push_back(8'h81);
`ifdef RADIATION_SENSOR_APP_OVFL_STATUS_EN
    exp_q.push_back({7'b0, m_ovf});
`endif
    exp_q.push_back(m_count[15:8]);
    exp_q.push_back(m_count[7:0]);
  endtask

  // Called right after the triggering event: the first byte must be up one cycle later.
  task automatic collect_reply(input string tag);
    int n;
    logic [7:0] e;
    n = exp_q.size();
    tick();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s valid%0d", tag, i), {31'b0, tx_data_valid}, 32'd1);
      check($sformatf("%s byte%0d", tag, i), {24'b0, tx_data}, {24'b0, e});
      repeat (7) tick();
      tx_req = 1'b1;
      tick();
      tx_req = 1'b0;
    end
    check({tag, " end"}, {31'b0, tx_data_valid}, 32'd0);
  endtask

  task automatic expect_silence(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | tx_data_valid;
    end
    check({tag, " no reply"}, {31'b0, seen}, 32'd0);
  endtask

  task automatic pulse_resend();
    resend_last = 1'b1;
    tick();
    resend_last = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("reset tx_data", {24'b0, tx_data}, 32'd0);
    check("reset tx_valid", {31'b0, tx_data_valid}, 32'd0);

    // Five hits then READ_COUNT.
    repeat (5) hit();
    push_count();
    send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0);
    collect_reply("count5");

    // CLEAR with a hit on its DECODE cycle: the hit is dropped.
    exp_q.push_back(8'h82);
    send_frame(8'h02, 8'h00, 1, 1'b0, 1'b1);
    m_count = 16'h0000;
    m_ovf   = 1'b0;
    collect_reply("clear");
    repeat (4) tick();
    push_count();
    send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0);
    collect_reply("count_after_clear");

    exp_q.push_back(8'h83);
    exp_q.push_back(8'h01);
    send_frame(8'h03, 8'h00, 1, 1'b0, 1'b0);
    collect_reply("version");

    exp_q.push_back(8'hFF);
    send_frame(8'h7E, 8'h00, 1, 1'b0, 1'b0);
    collect_reply("unknown");

    // Discarded frames, then a replay proving they changed nothing.
    send_frame(8'h01, 8'h01, 2, 1'b0, 1'b0);
    expect_silence("two_bytes");
    send_frame(8'h01, 8'h00, 1, 1'b1, 1'b0);
    expect_silence("rx_error");
    send_frame(8'h00, 8'h00, 0, 1'b0, 1'b0);
    expect_silence("empty");
    exp_q.push_back(8'hFF);
    pulse_resend();
    collect_reply("resend_unknown");

    // READ_COUNT with count 2, then 4 more hits, then replay of the snapshot.
    repeat (2) hit();
    push_count();
    send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0);
    collect_reply("count2");
    repeat (4) hit();
    exp_q.push_back(8'h81);
`ifdef RADIATION_SENSOR_APP_OVFL_STATUS_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    pulse_resend();
    collect_reply("resend_count2");

    // Saturation: preload near the top, then three hits.
    force dut.count_q = 16'hFFFE;
    tick();
    release dut.count_q;
    m_count = 16'hFFFE;
    repeat (3) hit();
    check("ovf flag", {31'b0, dut.ovf_q}, {31'b0, m_ovf});
    push_count();
    send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0);
    collect_reply("saturated");

    // rx_soc after the first tx_req aborts the reply.
    send_frame(8'h01, 8'h00, 1, 1'b0, 1'b0);
    tick();
    check("abort first byte", {24'b0, tx_data}, 32'h81);
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    check("abort second valid", {31'b0, tx_data_valid}, 32'd1);
    rx_soc = 1'b1;
    tick();
    rx_soc = 1'b0;
    check("abort valid drop", {31'b0, tx_data_valid}, 32'd0);
    rx_eoc = 1'b1;
    tick();
    rx_eoc = 1'b0;
    tick();

    // Reset mid-TX clears outputs and the buffer; resend is then ignored.
    send_frame(8'h03, 8'h00, 1, 1'b0, 1'b0);
    tick();
    check("rst pre valid", {31'b0, tx_data_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst tx_valid", {31'b0, tx_data_valid}, 32'd0);
    check("rst tx_data", {24'b0, tx_data}, 32'd0);
    pulse_resend();
    expect_silence("resend_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/radiation_sensor_app.md
# radiation_sensor_app

Application layer of the radiation sensor tag. It sits directly downstream of the ISO/IEC 14443A core's byte-wide application RX port and drives that core's application TX port. It counts synchronised hit pulses from the analogue front end, decodes one-byte commands, and builds the reply frames: count readout, clear, and version. On request it replays its last reply.

## Interface
- `VERSION`, default 8'h01: firmware/version byte returned by READ_VERSION.
- `clk`  in  1: 13.56 MHz recovered carrier clock.
- `rst`  in  1: synchronous, active-high reset.
- `hit_async`  in  1: asynchronous hit indication from the analogue block; level, min high 2 clk.
- `rx_soc`  in  1: one-cycle pulse, start of received frame.
- `rx_eoc`  in  1: one-cycle pulse, end of received frame.
- `rx_data`  in  8: received byte, valid when `rx_data_valid`.
- `rx_data_valid`  in  1: one-cycle pulse per received byte.
- `rx_error`  in  1: frame error; sampled at `rx_eoc`.
- `resend_last`  in  1: one-cycle pulse, core requests retransmission of previous reply.
- `tx_req`  in  1: one-cycle pulse, core has consumed current `tx_data`.
- `tx_data`  out  8: reply byte.
- `tx_data_valid`  out  1: high for whole reply; low marks end of frame.

## Operation
- Hit path: 2-FF synchroniser plus rising-edge detect on `hit_async`. Each edge increments the 16-bit `count`. `count` saturates at 16'hFFFF and sets the sticky `ovf` flag.
- Commands are 1-byte frames:
  - 8'h01 READ_COUNT replies 8'h81, count[15:8], count[7:0].
  - 8'h02 CLEAR replies 8'h82 and zeroes `count` and `ovf`.
  - 8'h03 READ_VERSION replies 8'h83, VERSION.
  - Any other byte replies 8'hFF.
- Frames are discarded with no reply and no state change when any of these hold: `rx_error` is set at `rx_eoc`, the frame has 0 bytes, or the frame has more than 1 byte.
- FSM states and transitions:
  - IDLE: goes to RX on `rx_soc`.
  - RX: latches the first byte and counts bytes, saturating at 2. On `rx_eoc` it goes to DECODE if valid, else IDLE.
  - DECODE: one cycle. Snapshots `count`/`ovf`, fills the 4x8 reply buffer and `reply_len`, applies CLEAR, then goes to TX.
  - TX: presents `buf[idx]`; each `tx_req` increments `idx`. After `tx_req` on `idx == reply_len-1`, goes to IDLE.
- `resend_last` in IDLE with `reply_len != 0` goes to TX with idx 0 and replays the buffer unchanged. There is no re-snapshot and CLEAR is not re-applied. If `reply_len == 0`, it is ignored.
- `rx_soc` while in TX aborts the reply: `tx_data_valid` drops next cycle and the FSM enters RX.
- `resend_last` outside IDLE is ignored.
- Hit and CLEAR in the same cycle: CLEAR wins, and the hit is dropped.
- Hits during RX/TX keep counting. The reply reflects the DECODE snapshot.

## Timing
- Reset values:
  - `tx_data` = 0, `tx_data_valid` = 0.
  - `count` = 0, `ovf` = 0.
  - `reply_len` = 0, state IDLE.
  - Synchroniser flops = 0.
- Hit latency: `count` updates 3 clk after the `hit_async` rise.
- `rx_eoc` at cycle N: DECODE at N+1; `tx_data_valid` = 1 with byte 0 at N+2.
- `tx_req` at cycle M: next byte on `tx_data` at M+1. After the last byte, `tx_data_valid` = 0 at M+1.
- `resend_last` at cycle N: `tx_data_valid` = 1 at N+1.
- `rst` asserted mid-TX: `tx_data_valid` = 0 the next cycle and the buffer is cleared.

## Configuration
- `RADIATION_SENSOR_APP_OVFL_STATUS_EN`:
  - Defined: the READ_COUNT reply is 4 bytes: 8'h81, {7'b0, ovf}, count[15:8], count[7:0].
  - Undefined: the reply is 3 bytes, and `ovf` logic is still present but unreported.
- The reply buffer depth is 4 in both builds.

## Structure
- `radiation_sensor_app_pkg` holds:
  - Command codes: CMD_READ_COUNT, CMD_CLEAR, CMD_READ_VERSION.
  - Reply codes: RSP_* and RSP_UNKNOWN = 8'hFF.
  - The state enum `AppState` {IDLE, RX, DECODE, TX}.
- Sub-module `hit_edge_detector`: 2-FF synchroniser and rising-edge pulse, with a synchronous active-high reset.

## Test plan
- 5 hit edges, then frame {8'h01} with `tx_req` every 8 clk. Reply is 8'h81, 8'h00, 8'h05, with `tx_data_valid` low after the third `tx_req`. With the macro, the reply is 8'h81, 8'h00, 8'h00, 8'h05.
- Preload `count` to 16'hFFFE, then 3 hits, then READ_COUNT. Count bytes are 8'hFF, 8'hFF, and the status byte is 8'h01 when the macro is defined.
- Frame {8'h02} with a hit on its DECODE cycle. Reply is 8'h82, and a following READ_COUNT returns count 0.
- Frame {8'h03} replies 8'h83, VERSION. Frame {8'h7E} replies 8'hFF. Frames {8'h01, 8'h01}, {8'h01} with `rx_error`, and an empty frame produce no `tx_data_valid`.
- READ_COUNT (count = 2), then 4 hits, then `resend_last`. Replay is identical: 8'h81, 8'h00, 8'h02.
- `rx_soc` after the first `tx_req`: `tx_data_valid` = 0 next cycle. `rst` mid-TX: all outputs are 0, and `resend_last` afterwards is ignored.
